// File: rtl/mem_initiator_pkg.sv
// Shared encodings for the memory initiator: transfer sizes, read/write
// polarity of the memory_unit handshake, and the initiator FSM states.
package mem_initiator_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_WORD  = 2'b01;
  localparam logic [1:0] SZ_HALF  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    RELEASE,
    DONE,
    ERR
  } state_t;

  // A doubleword is moved as two word beats, so memory never sees 2'b11.
  function automatic logic [1:0] size_to_sel(input logic [1:0] size);
    return (size == SZ_DWORD) ? SZ_WORD : size;
  endfunction

  function automatic logic [31:0] read_mask(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: return {24'b0, data[7:0]};
      SZ_HALF: return {16'b0, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Memory-side bus between the initiator and memory_unit.
interface mem_initiator_if;

  logic        Enable;
  logic        ReadWrite;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [1:0]  wordSelector;
  logic [31:0] DataOut;
  logic        MFC;

  modport master (
    output Enable, ReadWrite, Address, DataIn, wordSelector,
    input  DataOut, MFC
  );

  modport slave (
    input  Enable, ReadWrite, Address, DataIn, wordSelector,
    output DataOut, MFC
  );

endinterface

// File: rtl/mem_initiator_mfc_wait_timer.sv
// Counts cycles spent waiting for an MFC level; expired marks the last
// permitted waiting cycle so the FSM can abort on that edge.
module mfc_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CW'(TIMEOUT))) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_initiator.sv
// CPU-to-memory_unit initiator: one request becomes one or two
// setup/strobe/release beats, with an MFC timeout abort.
module mem_initiator
  import mem_initiator_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata0,
  output logic [31:0]       rdata1,
  mem_initiator_if.master   mem
);

  state_t      state, state_nx;
  logic [1:0]  rst_sync;
  logic        rst_n_int;
  logic [1:0]  size_q;
  logic [31:0] wdata1_q;
  logic        beat;
  logic [31:0] addr_r;
  logic [31:0] data_r;
  logic        rw_r;
  logic [1:0]  sel_r;
  logic        enable_r;
  logic        timer_en;
  logic        timer_clear;
  logic        expired;
  logic        second_beat_due;

  // Assertion propagates asynchronously; release is delayed two clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_n_int       = rst_sync[1];
  assign second_beat_due = (size_q == SZ_DWORD) && !beat;
  assign timer_clear     = (state_nx != state);

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    enable_r = 1'b0;
    timer_en = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nx = SETUP;
      end
      SETUP: begin
        busy     = 1'b1;
        state_nx = STROBE;
      end
      STROBE: begin
        busy     = 1'b1;
        enable_r = 1'b1;
        timer_en = 1'b1;
        if (mem.MFC)      state_nx = RELEASE;
        else if (expired) state_nx = ERR;
      end
      RELEASE: begin
        busy     = 1'b1;
        timer_en = 1'b1;
        if (!mem.MFC)     state_nx = second_beat_due ? SETUP : DONE;
        else if (expired) state_nx = ERR;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      ERR: begin
        err      = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bus registers are loaded a full SETUP cycle ahead of Enable.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      size_q   <= SZ_WORD;
      wdata1_q <= '0;
      beat     <= 1'b0;
      addr_r   <= '0;
      data_r   <= '0;
      rw_r     <= RW_READ;
      sel_r    <= SZ_WORD;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            size_q   <= size;
            wdata1_q <= wdata1;
            beat     <= 1'b0;
            addr_r   <= 32'(addr);
            data_r   <= wdata0;
            rw_r     <= wr ? RW_WRITE : RW_READ;
            sel_r    <= size_to_sel(size);
          end
        end
        STROBE: begin
          if (mem.MFC && (rw_r == RW_READ)) begin
            if (beat) rdata1 <= read_mask(size_q, mem.DataOut);
            else      rdata0 <= read_mask(size_q, mem.DataOut);
          end
        end
        RELEASE: begin
          if (!mem.MFC && second_beat_due) begin
            beat   <= 1'b1;
            addr_r <= addr_r + 32'd4;
            data_r <= wdata1_q;
          end
        end
        default: ;
      endcase
    end
  end

  mfc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n_int),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (expired)
  );

  assign mem.Enable       = enable_r;
  assign mem.ReadWrite    = rw_r;
  assign mem.Address      = addr_r;
  assign mem.DataIn       = data_r;
  assign mem.wordSelector = sel_r;

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15: maximum cycles spent waiting on an MFC edge before abort.
REQ-002 The block SHALL have parameter ADDR_W, default 32: address width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  CPU request strobe; sampled only in IDLE.
REQ-006 wr  input  1  1 = write, 0 = read; sampled with req.
REQ-007 size  input  2  00 byte, 01 word, 10 halfword, 11 doubleword (two word beats); sampled with req.
REQ-008 addr  input  ADDR_W  request address; sampled with req.
REQ-009 wdata0, wdata1  input  32 each  write data for beat 0 and beat 1; beat 1 is used only for doubleword.
REQ-010 busy  output  1  high from request acceptance until done or err.
REQ-011 done  output  1  one-cycle pulse on successful completion.
REQ-012 err  output  1  one-cycle pulse on timeout abort.
REQ-013 rdata0, rdata1  output  32 each  captured read data for beat 0 and beat 1 (the MDR pair).
REQ-014 Enable  output  1  memory enable to memory_unit.
REQ-015 ReadWrite  output  1  1 = read, 0 = write, matching memory_unit.
REQ-016 Address  output  32  memory address; zero-extended from ADDR_W.
REQ-017 DataIn  output  32  memory write data.
REQ-018 wordSelector  output  2  transfer size to memory; 00, 01 or 10 only.
REQ-019 DataOut  input  32  memory read data.
REQ-020 MFC  input  1  memory function complete, from memory_unit.

Function
REQ-021 States SHALL be IDLE, SETUP, STROBE, RELEASE, DONE and ERR.
REQ-022 IDLE: when req=1, latch wr, size, addr, wdata0 and wdata1; set beat=0; go to SETUP; raise busy on the next cycle.
REQ-023 SETUP: drive Address, DataIn, ReadWrite and wordSelector with Enable=0 for exactly one cycle, then go to STROBE.
REQ-024 Address/data setup SHALL therefore precede the Enable rise by at least one cycle.
REQ-025 STROBE: hold Enable=1 and all other memory outputs stable until MFC=1 is sampled.
REQ-026 On sampling MFC=1 during a read, capture DataOut into rdata[beat] on the same edge, then go to RELEASE.
REQ-027 For a byte read, rdata[beat] SHALL be {24'b0, DataOut[7:0]}.
REQ-028 For a halfword read, rdata[beat] SHALL be {16'b0, DataOut[15:0]}.
REQ-029 RELEASE: drive Enable=0 and wait for MFC=0, so that a slow or level-held MFC is never double-counted.
REQ-030 On leaving RELEASE: if size=11 and beat=0, set beat=1, Address=addr+4 (mod 2^32), DataIn=wdata1, and go to SETUP.
REQ-031 On leaving RELEASE in every other case, go to DONE.
REQ-032 A doubleword SHALL use wordSelector=01 on both beats.
REQ-033 DONE: pulse done for one cycle, deassert busy, return to IDLE.
REQ-034 The earliest new request is accepted on the cycle after DONE.
REQ-035 Timeout: a wait counter SHALL clear on entry to STROBE and on entry to RELEASE, and increment each cycle in those states.
REQ-036 When the wait counter reaches TIMEOUT without the awaited MFC level, go to ERR.
REQ-037 ERR: Enable=0, pulse err for one cycle, deassert busy, return to IDLE; rdata of an unfinished beat SHALL be left unchanged.
REQ-038 req while busy SHALL be ignored, with no queuing.
REQ-039 MFC=1 sampled in IDLE or SETUP SHALL be ignored.
REQ-040 Minimum latency from req to done with a same-cycle-responding memory: 4 cycles single-beat, 7 cycles doubleword.
REQ-041 rdata0 and rdata1 SHALL hold their values until overwritten by a later read.
REQ-042 A write SHALL not modify rdata.

Reset
REQ-043 Reset assertion SHALL force IDLE immediately, without waiting for clk.
REQ-044 Reset values SHALL be: Enable=0, ReadWrite=1, Address=0, DataIn=0, wordSelector=01, busy=0, done=0, err=0, rdata0=0, rdata1=0, beat=0, wait counter=0.
REQ-045 Reset asserted mid-transfer SHALL abandon the transfer with no done or err pulse.
REQ-046 Reset deassertion SHALL be synchronised internally before it releases the FSM.

Structure
REQ-047 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_WORD, SZ_HALF, SZ_DWORD), the ReadWrite encodings (RW_READ=1, RW_WRITE=0) and the FSM state enumeration.
REQ-048 One sub-module, mfc_wait_timer, SHALL hold the wait counter and compare; inputs clear and enable, output expired.

Verification
REQ-049 Word write then read: write addr 0x10, wdata0 0xDEADBEEF; read addr 0x10 -> memory holds the value; rdata0=0xDEADBEEF; done pulses once per request; Enable rises one cycle after Address is stable.
REQ-050 Byte read: memory word at 0x20 = 0xAABBCCDD, size=00 -> wordSelector=00, rdata0=0x000000DD.
REQ-051 Doubleword read from 0x30, memory holding 0x11111111 and 0x22222222 -> two Enable pulses at Address 0x30 then 0x34; rdata0=0x11111111, rdata1=0x22222222; done pulses after the second beat only.
REQ-052 MFC held low, TIMEOUT=15 -> err pulses after 15 STROBE cycles, Enable returns to 0, busy falls, done never pulses.
REQ-053 rst_n driven low in STROBE mid-read -> Enable=0 and busy=0 asynchronously, no done or err pulse; a following word read completes normally.
REQ-054 MFC stuck high after a beat -> FSM stays in RELEASE until MFC falls or err fires; a second req during busy is ignored and no extra transfer occurs.
